mc_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS core (mcmips). It sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch/decode/execute/memory/writeback for each instruction. It drives all mux selects and write enables. It stalls on a single-port memory through a ready handshake.

---
 rtl/mc_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: main control FSM sequencing the multi-cycle MIPS datapath.
// Define MC_CTRL_TRAP_EN for a sticky TRAP state and the Trap output.
module mc_ctrl #(
   parameter logic FETCH_ADDR_SEL = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       BrTaken,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemToReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] State,
   output logic       InsDone
`ifdef MC_CTRL_TRAP_EN
   ,
   output logic       Trap
`endif
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_BRANCH = 3'd5;
   localparam logic [2:0] S_JUMP   = 3'd6;
`ifdef MC_CTRL_TRAP_EN
   localparam logic [2:0] S_TRAP   = 3'd7;
`endif

   logic [2:0] r_state;
   logic [2:0] w_next;

   logic w_rform, w_jr, w_j, w_jal, w_br;
   logic w_ialu, w_lw, w_sw, w_ldst;
   logic w_exec, w_jump, w_nop;

   assign w_rform = (Opcode == 6'h00);
   assign w_jr    = w_rform && (Funct == 6'h08);
   assign w_j     = (Opcode == 6'h02);
   assign w_jal   = (Opcode == 6'h03);
   assign w_br    = (Opcode == 6'h04) || (Opcode == 6'h05)
                 || (Opcode == 6'h07);
   assign w_ialu  = (Opcode[5:3] == 3'b001);
   assign w_lw    = (Opcode == 6'h23);
   assign w_sw    = (Opcode == 6'h2B);
   assign w_ldst  = w_lw || w_sw;
   assign w_exec  = (w_rform && !w_jr) || w_ialu || w_ldst;
   assign w_jump  = w_j || w_jal || w_jr;

`ifdef MC_CTRL_TRAP_EN
   logic w_fn_ok, w_known;
   assign w_fn_ok = (Funct inside {6'h00, 6'h02, 6'h03, 6'h04,
                    6'h06, 6'h07, 6'h08, 6'h20, 6'h21, 6'h22,
                    6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                    6'h2B});
   assign w_known = w_rform ? w_fn_ok
                  : (w_jump || w_br || w_ialu || w_ldst);
   assign w_nop   = 1'b0;
   assign Trap    = !RST && (r_state == S_TRAP);
`else
   assign w_nop   = !(w_jump || w_br || w_exec);
`endif

   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (w_jump)      w_next = S_JUMP;
            else if (w_br)   w_next = S_BRANCH;
            else if (w_exec) w_next = S_EXEC;
`ifdef MC_CTRL_TRAP_EN
            if (!w_known)    w_next = S_TRAP;
`endif
         end
         S_EXEC:   w_next = w_ldst ? S_MEM : S_WB;
         S_MEM: begin
            if (!MemReady)   w_next = S_MEM;
            else if (w_lw)   w_next = S_WB;
            else             w_next = S_FETCH;
         end
`ifdef MC_CTRL_TRAP_EN
         S_TRAP:   w_next = S_TRAP;
`endif
         default:  w_next = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite  = 1'b0;
      PCSrc    = 2'd0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 2'd0;
      MemToReg = 2'd0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'd0;
      ALUOp    = 2'd0;
      InsDone  = 1'b0;
      State    = RST ? S_FETCH : r_state;
      // Reset gates every control output, whatever state is held.
      if (!RST) begin
         case (r_state)
            S_FETCH: begin
               IorD    = FETCH_ADDR_SEL;
               MemRead = 1'b1;
               ALUSrcB = 2'd1;
               IRWrite = MemReady;
               PCWrite = MemReady;
            end
            S_DECODE: begin
               ALUSrcB = 2'd3;
               InsDone = w_nop;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               if (w_ialu) begin
                  ALUSrcB = 2'd2;
                  ALUOp   = 2'd3;
               end else if (w_ldst) begin
                  ALUSrcB = 2'd2;
               end else begin
                  ALUOp   = 2'd2;
               end
            end
            S_MEM: begin
               IorD     = ~FETCH_ADDR_SEL;
               MemRead  = w_lw;
               MemWrite = !w_lw;
               InsDone  = !w_lw && MemReady;
            end
            S_WB: begin
               RegWrite = 1'b1;
               InsDone  = 1'b1;
               RegDst   = w_rform ? 2'd1 : 2'd0;
               MemToReg = w_lw ? 2'd1 : 2'd0;
            end
            S_BRANCH: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'd1;
               PCSrc   = 2'd1;
               PCWrite = BrTaken;
               InsDone = 1'b1;
            end
            S_JUMP: begin
               PCSrc   = w_jr ? 2'd3 : 2'd2;
               PCWrite = 1'b1;
               InsDone = 1'b1;
               if (w_jal) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'd2;
                  MemToReg = 2'd2;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for the multi-cycle control FSM.
// Per-instruction cycle plans are queued and checked every cycle.
module tb_mc_ctrl;

   typedef struct packed {
      logic       pcw;
      logic [1:0] pcs;
      logic       irw;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       rw;
      logic [1:0] rdst;
      logic [1:0] m2r;
      logic       asa;
      logic [1:0] asb;
      logic [1:0] aop;
      logic [2:0] st;
      logic       done;
      logic       trap;
   } out_t;

   typedef enum int {
      C_R, C_I, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_NOP
   } cls_t;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [5:0] Opcode = 6'h00;
   logic [5:0] Funct = 6'h00;
   logic       BrTaken = 1'b0;
   logic       MemReady = 1'b0;
   logic       PCWrite, IRWrite, IorD, MemRead, MemWrite;
   logic       RegWrite, ALUSrcA, InsDone, Trap;
   logic [1:0] PCSrc, RegDst, MemToReg, ALUSrcB, ALUOp;
   logic [2:0] State;

   mc_ctrl u_dut (
      .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct),
      .BrTaken(BrTaken), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .State(State), .InsDone(InsDone)
`ifdef MC_CTRL_TRAP_EN
      , .Trap(Trap)
`endif
   );

`ifndef MC_CTRL_TRAP_EN
   assign Trap = 1'b0;
`endif

   always #5 CLK = ~CLK;

   out_t  w_act;
   assign w_act = {PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite,
                   RegWrite, RegDst, MemToReg, ALUSrcA, ALUSrcB,
                   ALUOp, State, InsDone, Trap};

   out_t  q_exp[$];
   string q_tag[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic [5:0] cur_op = 6'h00;
   logic [5:0] cur_fn = 6'h00;

   initial forever begin
      out_t  e;
      string t;
      @(negedge CLK);
      if (q_exp.size() > 0) begin
         e = q_exp.pop_front();
         t = q_tag.pop_front();
         n_cmp++;
         if (w_act !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", t, $time, w_act, e);
         end
         n_cmp++;
         if (MemRead === 1'b1 && MemWrite === 1'b1) begin
            n_bad++;
            $display("FAIL %s_rdwr: got MemRead=1 MemWrite=1 want exclusive", t);
         end
      end
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic cls_t classify(input logic [5:0] op,
                                     input logic [5:0] fn);
      if (op == 6'h00) return (fn == 6'h08) ? C_JR : C_R;
      if (op == 6'h02) return C_J;
      if (op == 6'h03) return C_JAL;
      if (op == 6'h04 || op == 6'h05 || op == 6'h07) return C_BR;
      if (op >= 6'h08 && op <= 6'h0F) return C_I;
      if (op == 6'h23) return C_LW;
      if (op == 6'h2B) return C_SW;
      return C_NOP;
   endfunction

   task automatic cyc(input out_t e, input logic rst, input logic mr,
                      input logic br, input string tag);
      @(posedge CLK);
      #1;
      RST      = rst;
      MemReady = mr;
      BrTaken  = br;
      Opcode   = cur_op;
      Funct    = cur_fn;
      q_exp.push_back(e);
      q_tag.push_back(tag);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic br, input int fw, input int mw,
                            input bit rst_mid);
      out_t e;
      cls_t c;
      cur_op = op;
      cur_fn = fn;
      c = classify(op, fn);
      e = '0;
      e.mrd = 1'b1;
      e.asb = 2'd1;
      for (int i = 0; i < fw; i++) cyc(e, 1'b0, 1'b0, rb(), "fetch_wait");
      e.irw = 1'b1;
      e.pcw = 1'b1;
      cyc(e, 1'b0, 1'b1, rb(), "fetch");
      e = '0;
      e.st  = 3'd1;
      e.asb = 2'd3;
      if (c == C_NOP) begin
         e.done = 1'b1;
         cyc(e, 1'b0, rb(), rb(), "decode_nop");
         return;
      end
      cyc(e, 1'b0, rb(), rb(), "decode");
      e = '0;
      if (c == C_R || c == C_I || c == C_LW || c == C_SW) begin
         e.st  = 3'd2;
         e.asa = 1'b1;
         e.asb = (c == C_R) ? 2'd0 : 2'd2;
         e.aop = (c == C_R) ? 2'd2 : (c == C_I) ? 2'd3 : 2'd0;
         cyc(e, 1'b0, rb(), rb(), "exec");
         e = '0;
         if (c == C_LW || c == C_SW) begin
            e.st   = 3'd3;
            e.iord = 1'b1;
            e.mrd  = (c == C_LW);
            e.mwr  = (c == C_SW);
            for (int i = 0; i < mw; i++) begin
               cyc(e, 1'b0, 1'b0, rb(), "mem_wait");
               if (rst_mid) begin
                  cyc('0, 1'b1, rb(), rb(), "reset_mid");
                  cyc('0, 1'b1, rb(), rb(), "reset_mid");
                  return;
               end
            end
            e.done = (c == C_SW);
            cyc(e, 1'b0, 1'b1, rb(), "mem");
            if (c == C_SW) return;
            e = '0;
         end
         e.st   = 3'd4;
         e.rw   = 1'b1;
         e.done = 1'b1;
         e.rdst = (c == C_R) ? 2'd1 : 2'd0;
         e.m2r  = (c == C_LW) ? 2'd1 : 2'd0;
         cyc(e, 1'b0, rb(), rb(), "wb");
      end else if (c == C_BR) begin
         e.st   = 3'd5;
         e.asa  = 1'b1;
         e.aop  = 2'd1;
         e.pcs  = 2'd1;
         e.pcw  = br;
         e.done = 1'b1;
         cyc(e, 1'b0, rb(), br, "branch");
      end else begin
         e.st   = 3'd6;
         e.pcs  = (c == C_JR) ? 2'd3 : 2'd2;
         e.pcw  = 1'b1;
         e.done = 1'b1;
         if (c == C_JAL) begin
            e.rw   = 1'b1;
            e.rdst = 2'd2;
            e.m2r  = 2'd2;
         end
         cyc(e, 1'b0, rb(), rb(), "jump");
      end
   endtask

   logic [5:0] ops[14] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h07, 6'h08, 6'h0C, 6'h0F, 6'h23, 6'h2B,
                           6'h3F, 6'h10};
   logic [5:0] fns[5] = '{6'h20, 6'h08, 6'h22, 6'h25, 6'h2A};

   initial begin
      cyc('0, 1'b1, 1'b0, 1'b0, "reset");
      cyc('0, 1'b1, 1'b1, 1'b1, "reset");
      run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
      run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
      run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 1'b0);
      run_instr(6'h2B, 6'h11, 1'b0, 1, 2, 1'b0);
      run_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
      run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
      run_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);
      run_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b0);
      run_instr(6'h02, 6'h08, 1'b0, 2, 0, 1'b0);
      run_instr(6'h08, 6'h20, 1'b0, 0, 0, 1'b0);
`ifndef MC_CTRL_TRAP_EN
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
`endif
      run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b1);
      run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 300; k++) begin
         int oi;
`ifdef MC_CTRL_TRAP_EN
         oi = $urandom_range(0, 11);
`else
         oi = $urandom_range(0, 13);
`endif
         run_instr(ops[oi], fns[$urandom_range(0, 4)], rb(),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                   $urandom_range(0, 3), 1'b0);
      end
`ifdef MC_CTRL_TRAP_EN
      begin
         out_t e;
         cur_op = 6'h3F;
         e = '0;
         e.mrd = 1'b1;
         e.asb = 2'd1;
         e.irw = 1'b1;
         e.pcw = 1'b1;
         cyc(e, 1'b0, 1'b1, 1'b0, "trap_fetch");
         e = '0;
         e.st  = 3'd1;
         e.asb = 2'd3;
         cyc(e, 1'b0, 1'b1, 1'b0, "trap_decode");
         e = '0;
         e.st   = 3'd7;
         e.trap = 1'b1;
         for (int i = 0; i < 3; i++) cyc(e, 1'b0, rb(), rb(), "trap");
         cyc('0, 1'b1, 1'b0, 1'b0, "trap_reset");
         run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
      end
`endif
      cyc('0, 1'b1, 1'b0, 1'b0, "final_reset");
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++;
      if (q_exp.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
